// File: rtl/ttt_board_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_board_ctrl
//
// Tic-tac-toe game controller. It owns the two player boards, feeds them to
// an external combinational win detector, accepts one move at a time, and
// decides win / draw / next turn one cycle after each accepted move.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   new_game     synchronous clear of the whole game (highest priority)
//   move_valid   move request strobe
//   move_pos     requested square 0..8 (same bit numbering as ain/bin)
//   move_ready   a move can be accepted this cycle
//   move_ack     1-cycle pulse: the previous request was accepted
//   move_err     1-cycle pulse: the previous request was illegal
//   ain, bin     registered boards of players A and B
//   win_line     detector result; only bits 7:0 carry information
//   turn         player to move (0 = A, 1 = B)
//   game_over    game has ended (win or draw)
//   winner       winning player, valid when game_over & ~draw
//   draw         game ended on a full board without a line
//   win_lq       win_line[7:0] captured when the win was found
//   move_count   number of occupied squares 0..9
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ttt_board_ctrl #(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_err,
    output logic [8:0] ain,
    output logic [8:0] bin,
    input  logic [8:0] win_line,
    output logic       turn,
    output logic       game_over,
    output logic       winner,
    output logic       draw,
    output logic [7:0] win_lq,
    output logic [3:0] move_count
);

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_CHECK = 2'd1,
        S_WIN   = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    state_t     r_state,  w_state_next;
    logic [8:0] r_ain,    w_ain_next;
    logic [8:0] r_bin,    w_bin_next;
    logic       r_turn,   w_turn_next;
    logic       r_ack,    w_ack_next;
    logic       r_err,    w_err_next;
    logic       r_over,   w_over_next;
    logic       r_winner, w_winner_next;
    logic       r_draw,   w_draw_next;
    logic [7:0] r_wlq,    w_wlq_next;
    logic [3:0] r_count,  w_count_next;

    logic [8:0] w_pos_onehot;
    logic       w_legal;
    logic       w_unused;

    // Bit 8 of the detector bus has no meaning for this controller.
    assign w_unused = win_line[8];

    // Shifting a 9-bit one by 9..15 yields zero, so out-of-range squares
    // never alias onto a real board bit; the range test rejects them anyway.
    assign w_pos_onehot = 9'(9'd1 << move_pos);
    assign w_legal      = (move_pos <= 4'd8) && (((r_ain | r_bin) & w_pos_onehot) == 9'd0);

    always_comb begin
        w_state_next  = r_state;
        w_ain_next    = r_ain;
        w_bin_next    = r_bin;
        w_turn_next   = r_turn;
        w_ack_next    = 1'b0;
        w_err_next    = 1'b0;
        w_over_next   = r_over;
        w_winner_next = r_winner;
        w_draw_next   = r_draw;
        w_wlq_next    = r_wlq;
        w_count_next  = r_count;

        if (new_game) begin
            // Concurrent move requests are dropped without ack or err.
            w_state_next  = S_PLAY;
            w_ain_next    = 9'd0;
            w_bin_next    = 9'd0;
            w_turn_next   = FIRST_PLAYER;
            w_over_next   = 1'b0;
            w_winner_next = 1'b0;
            w_draw_next   = 1'b0;
            w_wlq_next    = 8'd0;
            w_count_next  = 4'd0;
        end else begin
            unique case (r_state)
                S_PLAY: begin
                    if (move_valid) begin
                        if (w_legal) begin
                            if (r_turn) begin
                                w_bin_next = r_bin | w_pos_onehot;
                            end else begin
                                w_ain_next = r_ain | w_pos_onehot;
                            end
                            w_count_next = r_count + 4'd1;
                            w_ack_next   = 1'b1;
                            w_state_next = S_CHECK;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    // The detector now sees the board including the new move;
                    // a line on the ninth move outranks the draw.
                    if (win_line[7:0] != 8'd0) begin
                        w_state_next  = S_WIN;
                        w_over_next   = 1'b1;
                        w_winner_next = r_turn;
                        w_wlq_next    = win_line[7:0];
                    end else if (r_count == 4'd9) begin
                        w_state_next = S_DRAW;
                        w_over_next  = 1'b1;
                        w_draw_next  = 1'b1;
                    end else begin
                        w_turn_next  = ~r_turn;
                        w_state_next = S_PLAY;
                    end
                end
                S_WIN, S_DRAW: begin
                    // Terminal: everything holds until new_game or reset.
                end
                default: begin
                    w_state_next = S_PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_PLAY;
            r_ain    <= 9'd0;
            r_bin    <= 9'd0;
            r_turn   <= FIRST_PLAYER;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= 1'b0;
            r_draw   <= 1'b0;
            r_wlq    <= 8'd0;
            r_count  <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_ain    <= w_ain_next;
            r_bin    <= w_bin_next;
            r_turn   <= w_turn_next;
            r_ack    <= w_ack_next;
            r_err    <= w_err_next;
            r_over   <= w_over_next;
            r_winner <= w_winner_next;
            r_draw   <= w_draw_next;
            r_wlq    <= w_wlq_next;
            r_count  <= w_count_next;
        end
    end

    assign move_ready = (r_state == S_PLAY) && !new_game;
    assign move_ack   = r_ack;
    assign move_err   = r_err;
    assign ain        = r_ain;
    assign bin        = r_bin;
    assign turn       = r_turn;
    assign game_over  = r_over;
    assign winner     = r_winner;
    assign draw       = r_draw;
    assign win_lq     = r_wlq;
    assign move_count = r_count;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_board_ctrl
//
// Two controllers (first player A and first player B) share one stimulus
// stream. Each has its own win detector and its own game model kept as a
// square-ownership array; a negedge process compares every output of both
// against the models each cycle, and directed checks pin known positions.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ttt_board_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       junk8 = 1'b0;

    logic [8:0] d_ain [2];
    logic [8:0] d_bin [2];
    logic [8:0] d_wl  [2];
    logic       d_ready [2];
    logic       d_ack [2];
    logic       d_err [2];
    logic       d_turn [2];
    logic       d_go [2];
    logic       d_wnr [2];
    logic       d_draw [2];
    logic [7:0] d_wlq [2];
    logic [3:0] d_cnt [2];

    int checks = 0;
    int errors = 0;

    // Eight lines; index = win_line bit.
    int lines [8][3] = '{'{6,7,8}, '{3,4,5}, '{0,1,2}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clk = ~clk;

    function automatic logic [7:0] detect(input logic [8:0] a, input logic [8:0] b);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if ((a[lines[i][0]] && a[lines[i][1]] && a[lines[i][2]]) ||
                (b[lines[i][0]] && b[lines[i][1]] && b[lines[i][2]]))
                r[i] = 1'b1;
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            assign d_wl[gi] = {junk8, detect(d_ain[gi], d_bin[gi])};
            ttt_board_ctrl #(.FIRST_PLAYER(gi == 1)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .new_game   (new_game),
                .move_valid (move_valid),
                .move_pos   (move_pos),
                .move_ready (d_ready[gi]),
                .move_ack   (d_ack[gi]),
                .move_err   (d_err[gi]),
                .ain        (d_ain[gi]),
                .bin        (d_bin[gi]),
                .win_line   (d_wl[gi]),
                .turn       (d_turn[gi]),
                .game_over  (d_go[gi]),
                .winner     (d_wnr[gi]),
                .draw       (d_draw[gi]),
                .win_lq     (d_wlq[gi]),
                .move_count (d_cnt[gi])
            );
        end
    endgenerate

    // ---------------- game model ----------------
    // own: 0 empty, 1 player A, 2 player B. phase: 0 waiting for move,
    // 1 move just placed (outcome decided next edge), 2 game finished.
    int         own [2][9];
    int         m_phase [2];
    logic       m_turn [2];
    logic       m_ack [2];
    logic       m_err [2];
    logic       m_go [2];
    logic       m_wnr [2];
    logic       m_draw [2];
    logic [7:0] m_wlq [2];

    function automatic logic [8:0] board_of(input int k, input int p);
        logic [8:0] r;
        r = 9'd0;
        for (int s = 0; s < 9; s++) if (own[k][s] == p) r[s] = 1'b1;
        return r;
    endfunction

    function automatic int filled(input int k);
        int n;
        n = 0;
        for (int s = 0; s < 9; s++) if (own[k][s] != 0) n++;
        return n;
    endfunction

    function automatic logic [7:0] lines_owned(input int k);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (own[k][lines[i][0]] != 0 &&
                own[k][lines[i][0]] == own[k][lines[i][1]] &&
                own[k][lines[i][0]] == own[k][lines[i][2]])
                r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_clear(input int k);
        for (int s = 0; s < 9; s++) own[k][s] = 0;
        m_phase[k] = 0;
        m_turn[k]  = (k == 1);
        m_ack[k]   = 1'b0;
        m_err[k]   = 1'b0;
        m_go[k]    = 1'b0;
        m_wnr[k]   = 1'b0;
        m_draw[k]  = 1'b0;
        m_wlq[k]   = 8'd0;
    endtask

    task automatic model_step();
        logic [7:0] wl;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || new_game) begin
                model_clear(k);
            end else begin
                m_ack[k] = 1'b0;
                m_err[k] = 1'b0;
                if (m_phase[k] == 1) begin
                    wl = lines_owned(k);
                    if (wl != 8'd0) begin
                        m_go[k] = 1'b1; m_wnr[k] = m_turn[k]; m_wlq[k] = wl; m_phase[k] = 2;
                    end else if (filled(k) == 9) begin
                        m_go[k] = 1'b1; m_draw[k] = 1'b1; m_phase[k] = 2;
                    end else begin
                        m_turn[k] = ~m_turn[k]; m_phase[k] = 0;
                    end
                end else if (m_phase[k] == 0 && move_valid) begin
                    if (move_pos > 4'd8) m_err[k] = 1'b1;
                    else if (own[k][move_pos] != 0) m_err[k] = 1'b1;
                    else begin
                        own[k][move_pos] = m_turn[k] ? 2 : 1;
                        m_ack[k] = 1'b1;
                        m_phase[k] = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk("ain",   k, 32'(d_ain[k]),   32'(board_of(k, 1)));
                chk("bin",   k, 32'(d_bin[k]),   32'(board_of(k, 2)));
                chk("count", k, 32'(d_cnt[k]),   32'(filled(k)));
                chk("ready", k, 32'(d_ready[k]), 32'((m_phase[k] == 0) && !new_game));
                chk("ack",   k, 32'(d_ack[k]),   32'(m_ack[k]));
                chk("err",   k, 32'(d_err[k]),   32'(m_err[k]));
                chk("turn",  k, 32'(d_turn[k]),  32'(m_turn[k]));
                chk("over",  k, 32'(d_go[k]),    32'(m_go[k]));
                chk("winner",k, 32'(d_wnr[k]),   32'(m_wnr[k]));
                chk("draw",  k, 32'(d_draw[k]),  32'(m_draw[k]));
                chk("win_lq",k, 32'(d_wlq[k]),   32'(m_wlq[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic ng, input logic mv, input logic [3:0] pos);
        new_game   = ng;
        move_valid = mv;
        move_pos   = pos;
        @(posedge clk);
        #2;
        new_game   = 1'b0;
        move_valid = 1'b0;
    endtask

    task automatic play(input logic [3:0] pos);
        step(1'b0, 1'b1, pos);
        $display("move pos=%0d ack=%0b err=%0b turn=%0b ain=%03h bin=%03h",
                 pos, d_ack[0], d_err[0], d_turn[0], d_ain[0], d_bin[0]);
        step(1'b0, 1'b0, 4'd0);
    endtask

    int draw_seq [9] = '{4, 0, 2, 6, 3, 5, 8, 1, 7};
    int diag_seq [9] = '{8, 1, 4, 5, 2, 6, 3, 7, 0};

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_ain", 0, 32'(d_ain[0]), 32'h0);
        chk("rst_turn1", 1, 32'(d_turn[1]), 32'h1);
        chk("rst_ready", 0, 32'(d_ready[0]), 32'h1);

        // A wins on the bottom row 6-7-8.
        play(4'd8); play(4'd0); play(4'd7); play(4'd1);
        step(1'b0, 1'b1, 4'd6);
        chk("row_ack", 0, 32'(d_ack[0]), 32'h1);
        chk("row_turn", 0, 32'(d_turn[0]), 32'h0);
        step(1'b0, 1'b0, 4'd0);
        chk("row_over", 0, 32'(d_go[0]), 32'h1);
        chk("row_winner", 0, 32'(d_wnr[0]), 32'h0);
        chk("row_wlq", 0, 32'(d_wlq[0]), 32'h01);
        chk("row_ain", 0, 32'(d_ain[0]), 32'h1C0);
        chk("row_bin", 0, 32'(d_bin[0]), 32'h003);
        chk("row_cnt", 0, 32'(d_cnt[0]), 32'h5);
        chk("row_ready", 0, 32'(d_ready[0]), 32'h0);

        // Illegal moves.
        step(1'b1, 1'b0, 4'd0);
        play(4'd4);
        step(1'b0, 1'b1, 4'd4);
        chk("occ_err", 0, 32'(d_err[0]), 32'h1);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd10);
        chk("range_err", 0, 32'(d_err[0]), 32'h1);
        step(1'b0, 1'b0, 4'd0);
        chk("ill_bin", 0, 32'(d_bin[0]), 32'h0);
        chk("ill_turn", 0, 32'(d_turn[0]), 32'h1);
        chk("ill_cnt", 0, 32'(d_cnt[0]), 32'h1);

        // Draw.
        step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) play(4'(draw_seq[i]));
        chk("drw_draw", 0, 32'(d_draw[0]), 32'h1);
        chk("drw_over", 0, 32'(d_go[0]), 32'h1);
        chk("drw_wlq", 0, 32'(d_wlq[0]), 32'h0);
        chk("drw_cnt", 0, 32'(d_cnt[0]), 32'h9);
        step(1'b0, 1'b1, 4'd4);
        chk("drw_noack", 0, 32'(d_ack[0]), 32'h0);
        chk("drw_noerr", 0, 32'(d_err[0]), 32'h0);

        // Win on the ninth square (diagonal 8-4-0).
        step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 9; i++) play(4'(diag_seq[i]));
        chk("diag_winner", 0, 32'(d_wnr[0]), 32'h0);
        chk("diag_draw", 0, 32'(d_draw[0]), 32'h0);
        chk("diag_wlq", 0, 32'(d_wlq[0]), 32'h40);
        chk("diag_over", 0, 32'(d_go[0]), 32'h1);

        // new_game in WIN with a concurrent move, then in PLAY.
        step(1'b1, 1'b1, 4'd3);
        chk("ngw_ack", 0, 32'(d_ack[0]), 32'h0);
        chk("ngw_ain", 0, 32'(d_ain[0]), 32'h0);
        chk("ngw_turn", 0, 32'(d_turn[0]), 32'h0);
        play(4'd2);
        step(1'b1, 1'b1, 4'd5);
        chk("ngp_ack", 0, 32'(d_ack[0]), 32'h0);
        chk("ngp_cnt", 0, 32'(d_cnt[0]), 32'h0);
        chk("ngp_turn1", 1, 32'(d_turn[1]), 32'h1);
        step(1'b0, 1'b1, 4'd3);
        chk("fp1_bin", 1, 32'(d_bin[1]), 32'h008);
        chk("fp1_ain", 1, 32'(d_ain[1]), 32'h000);
        chk("fp0_ain", 0, 32'(d_ain[0]), 32'h008);
        step(1'b0, 1'b0, 4'd0);

        // Asynchronous reset while in CHECK.
        step(1'b0, 1'b1, 4'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ain", 0, 32'(d_ain[0]), 32'h0);
        chk("arst_ack", 0, 32'(d_ack[0]), 32'h0);
        chk("arst_cnt", 0, 32'(d_cnt[0]), 32'h0);
        chk("arst_ready", 0, 32'(d_ready[0]), 32'h1);
        chk("arst_turn1", 1, 32'(d_turn[1]), 32'h1);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 4'd4);
        chk("post_ack", 0, 32'(d_ack[0]), 32'h1);
        chk("post_ain", 0, 32'(d_ain[0]), 32'h010);
        step(1'b0, 1'b0, 4'd0);

        // Random games, checked every cycle by the compare process.
        for (int i = 0; i < 1500; i++) begin
            junk8 = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 11)));
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
